cache_control_nway: RTL
=======================

# cache_control_nway

Control FSM for an N-way set-associative, write-back, write-allocate L1 cache. It is the parametrised successor of the 2-way controller. It sits between the CPU-side memory port, the externally built tag/valid/dirty/data arrays, and the physical-memory port, and it owns the per-set tree pseudo-LRU state. Compared with the 2-way controller it adds three behaviours: invalid-way-first victim selection, explicit writeback-then-refill sequencing, and a whole-cache flush (write back every dirty line).

## Interface
- WAYS, 4, associativity; power of 2, 2..8; WAY_W = $clog2(WAYS)
- SETS, 16, number of sets; power of 2, ≥2; SET_W = $clog2(SETS)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- mem_read / mem_write  in  1 each  CPU request; held until mem_resp; never both high
- set_idx  in  SET_W  set index of the CPU address; stable while the request is held
- flush_req  in  1  level request to write back all dirty lines
- flush_done  out  1  one-cycle pulse when the flush completes
- hit_vec / valid_vec / dirty_vec  in  WAYS each  array outputs for the set read in the previous cycle
- array_read  out  1  read enable for all arrays
- index_sel  out  1  array index mux: 0 = set_idx, 1 = flush_idx
- flush_idx  out  SET_W  flush set counter
- way_idx  out  WAY_W  selected way, used for the read-data mux, writeback data and the victim tag
- data_we / tag_we / valid_we / dirty_we  out  WAYS each  one-hot write enables; the valid write value is always 1
- dirty_in  out  1  value written to the dirty bit
- data_src  out  1  data write source: 0 = CPU wdata/byte-enables, 1 = pmem line
- mem_resp  out  1  one-cycle CPU completion pulse
- pmem_read / pmem_write  out  1  held until pmem_resp
- pmem_resp  in  1  physical-memory completion
- pmem_addr_sel  out  1  0 = CPU address, 1 = {array tag[way_idx], current index}
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOOKUP, WRITEBACK, REFILL, FL_READ, FL_CHECK, FL_WB.
- Default outputs are 0 unless listed for a state. array_read is 1 in IDLE and FL_READ. index_sel is 1 in all FL_* states.

**CPU request path**
- IDLE, on mem_read|mem_write: go to LOOKUP. Otherwise, on flush_req: clear flush_idx and go to FL_READ. A CPU request has priority over flush_req.
- LOOKUP, hit (any bit of hit_vec): way_idx = lowest set bit of hit_vec; a multi-hit is illegal, and the lowest index wins.
  - Assert mem_resp and update PLRU for that way.
  - On a write, also assert data_we[way] with data_src=0, and dirty_we[way] with dirty_in=1.
  - Next state: IDLE.
- LOOKUP, miss: choose the victim and latch it into way_idx.
  - Victim = lowest-index way with valid_vec=0; if all ways are valid, victim = PLRU victim.
  - Next state: WRITEBACK if the victim is valid and dirty, else REFILL.
- WRITEBACK: pmem_write=1, pmem_addr_sel=1. On pmem_resp go to REFILL.
- REFILL: pmem_read=1, pmem_addr_sel=0. On pmem_resp:
  - Assert data_we, tag_we and valid_we for the victim with data_src=1, and dirty_we with dirty_in=0.
  - Update PLRU for the victim.
  - Next state: IDLE, which re-reads the arrays; the following LOOKUP hits.

**PLRU**
- WAYS-1 bits per set, stored in an internal register array.
- Tree walk from the root: bit=0 means the victim is in the lower-index half, bit=1 the upper half.
- On an access, every node on the path to the accessed way is set to point away from it. For WAYS=2, accessing way0 sets the bit to 1.

**Flush path**
- FL_READ: array read of flush_idx; next state FL_CHECK.
- FL_CHECK: way_idx = lowest way with valid&dirty.
  - If one exists, go to FL_WB.
  - Else if flush_idx = SETS-1: pulse flush_done, go to IDLE.
  - Else increment flush_idx and go to FL_READ.
- FL_WB: pmem_write=1, pmem_addr_sel=1. On pmem_resp: dirty_we[way_idx] with dirty_in=0, then go to FL_READ for the same set.
- A flush does not change the PLRU state or the valid bits.

## Timing
- Reset (async): state=IDLE, all outputs 0, way_idx=0, flush_idx=0, all PLRU bits 0. pmem_read/pmem_write drop immediately, even mid-transfer.
- Read or write hit: request in IDLE at cycle 0; mem_resp in cycle 1 (LOOKUP).
- Clean miss: LOOKUP (1 cycle), then REFILL for (pmem latency) cycles, IDLE (1), LOOKUP hit, giving mem_resp 3 cycles plus pmem latency after the request.
- Dirty miss: the clean-miss latency plus the WRITEBACK pmem latency.
- pmem_resp arriving in the same cycle that pmem_read/pmem_write is first asserted is honoured.
- The pmem strobes and index/way selects are held constant while waiting for pmem_resp.
- flush_req asserted during a CPU miss is ignored until the FSM returns to IDLE with no CPU request pending.
- Flush of an all-clean cache takes 2×SETS cycles from FL_READ to flush_done.
- PLRU and array writes take effect at the posedge that leaves the writing state.

## Test plan
- WAYS=4, SETS=16, reset mid-REFILL:
  - rst → pmem_read=0 in the same cycle.
  - After release: IDLE, mem_resp=0, PLRU all 0.
- Cold read, set 3, pmem latency 5:
  - Victim is way0 (invalid-first).
  - REFILL → tag_we=0001, valid_we=0001, data_src=1.
  - mem_resp 8 cycles after the request.
- Write hit to way2 of set 5:
  - mem_resp in cycle 1, data_we=0100, data_src=0, dirty_we=0100, dirty_in=1.
  - PLRU bits for set 5 become {root=0, left=x, right=1}.
- Set 7, all ways valid, PLRU selects way1, way1 dirty:
  - WRITEBACK with pmem_addr_sel=1, way_idx=1.
  - Then REFILL with pmem_addr_sel=0.
  - Refill writes dirty_in=0 into way1.
- Flush with dirty lines {set 0 way3, set 15 way0}:
  - Exactly two pmem_write transactions, with dirty_we=1000 and then 0001.
  - One flush_done pulse after the set-15 check.
- flush_req and mem_read raised together in IDLE:
  - The CPU request is served first (mem_resp).
  - The flush then starts at flush_idx=0.

Source files
------------

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back/write-allocate L1 cache.
// Owns the per-set tree pseudo-LRU state and sequences hits, writeback/refill and whole-cache flush.
module cache_control_nway #(
    parameter int WAYS = 4,
    parameter int SETS = 16,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [SET_W-1:0] set_idx,
    input  logic             flush_req,
    output logic             flush_done,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    output logic             array_read,
    output logic             index_sel,
    output logic [SET_W-1:0] flush_idx,
    output logic [WAY_W-1:0] way_idx,
    output logic [WAYS-1:0]  data_we,
    output logic [WAYS-1:0]  tag_we,
    output logic [WAYS-1:0]  valid_we,
    output logic [WAYS-1:0]  dirty_we,
    output logic             dirty_in,
    output logic             data_src,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic             pmem_addr_sel,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WRITEBACK = 3'd2,
        REFILL    = 3'd3,
        FL_READ   = 3'd4,
        FL_CHECK  = 3'd5,
        FL_WB     = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic [SET_W-1:0] flush_idx_q, flush_idx_d;
    // Heap-ordered tree: node 1 is the root, node n has children 2n (lower half) and 2n+1.
    logic [WAYS-1:1]  plru_q [SETS];
    logic [WAYS-1:1]  plru_d [SETS];

    logic             plru_we_s;
    logic [WAY_W-1:0] plru_way_s;
    logic [WAY_W-1:0] hit_way_s, inv_way_s, victim_s, fl_way_s, way_idx_s;
    logic [WAYS-1:0]  vd_vec_s;
    logic             array_read_s, index_sel_s, dirty_in_s, data_src_s, mem_resp_s;
    logic             pmem_read_s, pmem_write_s, pmem_addr_sel_s, flush_done_s;
    logic [WAYS-1:0]  data_we_s, tag_we_s, valid_we_s, dirty_we_s;

    function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = {WAY_W{1'b0}};
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = WAY_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
        logic [WAYS-1:0] r;
        r    = {WAYS{1'b0}};
        r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:1] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W:0]   nxt;
        logic [WAY_W-1:0] v;
        node = WAY_W'(1'b1);
        v    = {WAY_W{1'b0}};
        for (int l = WAY_W - 1; l >= 0; l--) begin
            v[l] = bits[node];
            nxt  = {node, bits[node]};
            node = nxt[WAY_W-1:0];
        end
        return v;
    endfunction

    function automatic logic [WAYS-1:1] plru_touch(input logic [WAYS-1:1] bits,
                                                   input logic [WAY_W-1:0] w);
        logic [WAY_W-1:0] node;
        logic [WAY_W:0]   nxt;
        logic [WAYS-1:1]  r;
        node = WAY_W'(1'b1);
        r    = bits;
        for (int l = WAY_W - 1; l >= 0; l--) begin
            r[node] = ~w[l];
            nxt     = {node, w[l]};
            node    = nxt[WAY_W-1:0];
        end
        return r;
    endfunction

    assign hit_way_s = lowest_set(hit_vec);
    assign inv_way_s = lowest_set(~valid_vec);
    assign victim_s  = (&valid_vec) ? plru_victim(plru_q[set_idx]) : inv_way_s;
    assign vd_vec_s  = valid_vec & dirty_vec;
    assign fl_way_s  = lowest_set(vd_vec_s);

    // Next-state and per-state output decode.
    always_comb begin
        state_d         = state_q;
        way_d           = way_q;
        flush_idx_d     = flush_idx_q;
        way_idx_s       = way_q;
        plru_we_s       = 1'b0;
        plru_way_s      = way_q;
        array_read_s    = 1'b0;
        index_sel_s     = 1'b0;
        dirty_in_s      = 1'b0;
        data_src_s      = 1'b0;
        mem_resp_s      = 1'b0;
        pmem_read_s     = 1'b0;
        pmem_write_s    = 1'b0;
        pmem_addr_sel_s = 1'b0;
        flush_done_s    = 1'b0;
        data_we_s       = {WAYS{1'b0}};
        tag_we_s        = {WAYS{1'b0}};
        valid_we_s      = {WAYS{1'b0}};
        dirty_we_s      = {WAYS{1'b0}};
        case (state_q)
            IDLE: begin
                array_read_s = 1'b1;
                if (mem_read || mem_write) begin
                    state_d = LOOKUP;
                end else if (flush_req) begin
                    flush_idx_d = {SET_W{1'b0}};
                    state_d     = FL_READ;
                end else begin
                    state_d = IDLE;
                end
            end
            LOOKUP: begin
                if (|hit_vec) begin
                    way_idx_s  = hit_way_s;
                    way_d      = hit_way_s;
                    mem_resp_s = 1'b1;
                    plru_we_s  = 1'b1;
                    plru_way_s = hit_way_s;
                    if (mem_write) begin
                        data_we_s  = onehot(hit_way_s);
                        dirty_we_s = onehot(hit_way_s);
                        dirty_in_s = 1'b1;
                    end else begin
                        data_we_s = {WAYS{1'b0}};
                    end
                    state_d = IDLE;
                end else begin
                    way_idx_s = victim_s;
                    way_d     = victim_s;
                    if (valid_vec[victim_s] && dirty_vec[victim_s]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write_s    = 1'b1;
                pmem_addr_sel_s = 1'b1;
                if (pmem_resp) begin
                    state_d = REFILL;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            REFILL: begin
                pmem_read_s = 1'b1;
                if (pmem_resp) begin
                    data_we_s  = onehot(way_q);
                    tag_we_s   = onehot(way_q);
                    valid_we_s = onehot(way_q);
                    dirty_we_s = onehot(way_q);
                    data_src_s = 1'b1;
                    plru_we_s  = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = REFILL;
                end
            end
            FL_READ: begin
                array_read_s = 1'b1;
                index_sel_s  = 1'b1;
                state_d      = FL_CHECK;
            end
            FL_CHECK: begin
                index_sel_s = 1'b1;
                way_idx_s   = fl_way_s;
                way_d       = fl_way_s;
                if (|vd_vec_s) begin
                    state_d = FL_WB;
                end else if (flush_idx_q == SET_W'(SETS - 1)) begin
                    flush_done_s = 1'b1;
                    state_d      = IDLE;
                end else begin
                    flush_idx_d = flush_idx_q + SET_W'(1'b1);
                    state_d     = FL_READ;
                end
            end
            FL_WB: begin
                index_sel_s     = 1'b1;
                pmem_write_s    = 1'b1;
                pmem_addr_sel_s = 1'b1;
                if (pmem_resp) begin
                    dirty_we_s = onehot(way_q);
                    state_d    = FL_READ;
                end else begin
                    state_d = FL_WB;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // PLRU next value: only the set of the current CPU request is ever touched.
    always_comb begin
        plru_d = plru_q;
        if (plru_we_s) begin
            plru_d[set_idx] = plru_touch(plru_q[set_idx], plru_way_s);
        end else begin
            plru_d[set_idx] = plru_q[set_idx];
        end
    end

    // State, latched way, flush counter and PLRU registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            way_q       <= {WAY_W{1'b0}};
            flush_idx_q <= {SET_W{1'b0}};
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= {(WAYS - 1){1'b0}};
            end
        end else begin
            state_q     <= state_d;
            way_q       <= way_d;
            flush_idx_q <= flush_idx_d;
            plru_q      <= plru_d;
        end
    end

    // Reset forces every output low at once, including strobes of an in-flight transfer.
    assign array_read    = array_read_s & ~rst;
    assign index_sel     = index_sel_s & ~rst;
    assign flush_idx     = rst ? {SET_W{1'b0}} : flush_idx_q;
    assign way_idx       = rst ? {WAY_W{1'b0}} : way_idx_s;
    assign data_we       = rst ? {WAYS{1'b0}} : data_we_s;
    assign tag_we        = rst ? {WAYS{1'b0}} : tag_we_s;
    assign valid_we      = rst ? {WAYS{1'b0}} : valid_we_s;
    assign dirty_we      = rst ? {WAYS{1'b0}} : dirty_we_s;
    assign dirty_in      = dirty_in_s & ~rst;
    assign data_src      = data_src_s & ~rst;
    assign mem_resp      = mem_resp_s & ~rst;
    assign pmem_read     = pmem_read_s & ~rst;
    assign pmem_write    = pmem_write_s & ~rst;
    assign pmem_addr_sel = pmem_addr_sel_s & ~rst;
    assign flush_done    = flush_done_s & ~rst;
    assign busy          = (state_q != IDLE) & ~rst;

endmodule
